// File: rtl/pipe_ctrl_pkg.sv
// Shared types and constants for the pipeline hazard controller.
//   state_t      : controller FSM states
//   REG_X0       : architectural zero register index
//   stage_ctl_t  : per pipeline-register control bundle {en, r}
//   STG_*        : canned stage-control encodings
package pipe_ctrl_pkg;

  typedef enum logic [1:0] {
    RUN      = 2'd0,
    MEM_WAIT = 2'd1,
    ERR      = 2'd2
  } state_t;

  localparam logic [4:0] REG_X0 = 5'd0;

  typedef struct packed {
    logic en;
    logic r;
  } stage_ctl_t;

  localparam stage_ctl_t STG_RUN   = '{en: 1'b1, r: 1'b0};  // advance
  localparam stage_ctl_t STG_HOLD  = '{en: 1'b0, r: 1'b0};  // keep contents
  localparam stage_ctl_t STG_FLUSH = '{en: 1'b1, r: 1'b1};  // load a bubble
  localparam stage_ctl_t STG_RST   = '{en: 1'b0, r: 1'b1};  // reset drive

  // Counter width able to hold 0..max, never below one bit.
  function automatic int cnt_width(input int max);
    return (max < 1) ? 1 : $clog2(max + 1);
  endfunction

endpackage

// File: rtl/hazard_detect.sv
// Load-use hazard detection (combinational).
//   mem_read_ex          : EX instruction is a load
//   rd_ex                : EX destination register
//   rs1_id / rs2_id      : ID source registers
//   rs1_used / rs2_used  : ID instruction actually reads that source
//   load_use             : ID needs the load result before it exists
module hazard_detect
  import pipe_ctrl_pkg::*;
(
  input  logic       mem_read_ex,
  input  logic [4:0] rd_ex,
  input  logic [4:0] rs1_id,
  input  logic [4:0] rs2_id,
  input  logic       rs1_used,
  input  logic       rs2_used,
  output logic       load_use
);

  // x0 is never written, so a load targeting it cannot create a dependency.
  assign load_use = mem_read_ex && (rd_ex != REG_X0) &&
                    ((rs1_used && (rs1_id == rd_ex)) ||
                     (rs2_used && (rs2_id == rd_ex)));

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Central stall/flush controller for the 5-stage pipeline.
//   inputs : load-use fields (EX/ID), branch_taken_ex, dmem_req_mem, dmem_ready
//   outputs: pc_en, {ifid,idex,exmem,memwb}_{en,r} (combinational, same-edge),
//            mem_err (sticky timeout), stall_cnt (saturating pc_en=0 count)
module pipe_hazard_ctrl
  import pipe_ctrl_pkg::*;
#(
  parameter int MEM_TIMEOUT = 16,
  parameter int CNT_W       = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             MemRead_ex,
  input  logic [4:0]       rdAddr_ex,
  input  logic [4:0]       rs1Addr_id,
  input  logic [4:0]       rs2Addr_id,
  input  logic             rs1Used_id,
  input  logic             rs2Used_id,
  input  logic             branch_taken_ex,
  input  logic             dmem_req_mem,
  input  logic             dmem_ready,
  output logic             pc_en,
  output logic             ifid_en,
  output logic             ifid_r,
  output logic             idex_en,
  output logic             idex_r,
  output logic             exmem_en,
  output logic             exmem_r,
  output logic             memwb_en,
  output logic             memwb_r,
  output logic             mem_err,
  output logic [CNT_W-1:0] stall_cnt
);

  localparam int WC_W = cnt_width(MEM_TIMEOUT);
  localparam logic [WC_W-1:0] WC_LIMIT = WC_W'(MEM_TIMEOUT);

  state_t          state;
  logic [WC_W-1:0] wait_cnt;
  logic            load_use;
  logic            mem_stall;
  logic            freeze;
  stage_ctl_t      ifid, idex, exmem, memwb;

  hazard_detect u_hd (
    .mem_read_ex (MemRead_ex),
    .rd_ex       (rdAddr_ex),
    .rs1_id      (rs1Addr_id),
    .rs2_id      (rs2Addr_id),
    .rs1_used    (rs1Used_id),
    .rs2_used    (rs2Used_id),
    .load_use    (load_use)
  );

  assign mem_stall = dmem_req_mem && !dmem_ready;
  // In MEM_WAIT the outstanding access is already known; only ready matters.
  assign freeze    = ((state == RUN) && mem_stall) ||
                     ((state == MEM_WAIT) && !dmem_ready);

  always_comb begin
    pc_en = 1'b1;
    ifid  = STG_RUN;
    idex  = STG_RUN;
    exmem = STG_RUN;
    memwb = STG_RUN;
    if (!rst_n) begin
      pc_en = 1'b0;
      ifid  = STG_RST;
      idex  = STG_RST;
      exmem = STG_RST;
      memwb = STG_RST;
    end else if (state == ERR) begin
      pc_en = 1'b0;
      ifid  = STG_HOLD;
      idex  = STG_HOLD;
      exmem = STG_HOLD;
      memwb = STG_HOLD;
    end else if (freeze) begin
      // Everything up to MEM holds; WB gets a bubble so the waiting
      // instruction is not retired twice.
      pc_en = 1'b0;
      ifid  = STG_HOLD;
      idex  = STG_HOLD;
      exmem = STG_HOLD;
      memwb = STG_FLUSH;
    end else if (branch_taken_ex) begin
      // Kill the two wrong-path instructions; a pending load-use is moot.
      ifid = STG_FLUSH;
      idex = STG_FLUSH;
    end else if (load_use) begin
      pc_en = 1'b0;
      ifid  = STG_HOLD;
      idex  = STG_FLUSH;
    end
  end

  assign {ifid_en,  ifid_r}  = ifid;
  assign {idex_en,  idex_r}  = idex;
  assign {exmem_en, exmem_r} = exmem;
  assign {memwb_en, memwb_r} = memwb;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= RUN;
      wait_cnt  <= '0;
      mem_err   <= 1'b0;
      stall_cnt <= '0;
    end else begin
      if (!pc_en && (stall_cnt != {CNT_W{1'b1}}))
        stall_cnt <= stall_cnt + 1'b1;
      case (state)
        RUN: begin
          if (mem_stall) begin
            state    <= MEM_WAIT;
            wait_cnt <= WC_W'(1);
          end
        end
        MEM_WAIT: begin
          if (dmem_ready) begin
            state    <= RUN;
            wait_cnt <= '0;
          end else if ((MEM_TIMEOUT != 0) && (wait_cnt == WC_LIMIT)) begin
            state   <= ERR;
            mem_err <= 1'b1;
          end else if (wait_cnt != {WC_W{1'b1}}) begin
            // Saturate so a disabled timeout cannot wrap into a false match.
            wait_cnt <= wait_cnt + 1'b1;
          end
        end
        ERR: begin
          mem_err <= 1'b1;
        end
        default: begin
          state <= RUN;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Directed self-checking bench for pipe_hazard_ctrl (MEM_TIMEOUT=4, CNT_W=3).
module tb_pipe_hazard_ctrl;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       MemRead_ex;
  logic [4:0] rdAddr_ex, rs1Addr_id, rs2Addr_id;
  logic       rs1Used_id, rs2Used_id;
  logic       branch_taken_ex, dmem_req_mem, dmem_ready;
  logic       pc_en, ifid_en, ifid_r, idex_en, idex_r;
  logic       exmem_en, exmem_r, memwb_en, memwb_r, mem_err;
  logic [2:0] stall_cnt;

  int checks   = 0;
  int failures = 0;

  // {pc_en, ifid en/r, idex en/r, exmem en/r, memwb en/r}
  localparam logic [8:0] O_DEF = 9'b1_10_10_10_10;
  localparam logic [8:0] O_RST = 9'b0_01_01_01_01;
  localparam logic [8:0] O_LU  = 9'b0_00_11_10_10;
  localparam logic [8:0] O_BR  = 9'b1_11_11_10_10;
  localparam logic [8:0] O_FRZ = 9'b0_00_00_00_11;
  localparam logic [8:0] O_ERR = 9'b0_00_00_00_00;

  logic [8:0] outs;
  assign outs = {pc_en, ifid_en, ifid_r, idex_en, idex_r,
                 exmem_en, exmem_r, memwb_en, memwb_r};

  always #5 clk = ~clk;

  pipe_hazard_ctrl #(.MEM_TIMEOUT(4), .CNT_W(3)) dut (
    .clk(clk), .rst_n(rst_n), .MemRead_ex(MemRead_ex), .rdAddr_ex(rdAddr_ex),
    .rs1Addr_id(rs1Addr_id), .rs2Addr_id(rs2Addr_id), .rs1Used_id(rs1Used_id),
    .rs2Used_id(rs2Used_id), .branch_taken_ex(branch_taken_ex),
    .dmem_req_mem(dmem_req_mem), .dmem_ready(dmem_ready), .pc_en(pc_en),
    .ifid_en(ifid_en), .ifid_r(ifid_r), .idex_en(idex_en), .idex_r(idex_r),
    .exmem_en(exmem_en), .exmem_r(exmem_r), .memwb_en(memwb_en),
    .memwb_r(memwb_r), .mem_err(mem_err), .stall_cnt(stall_cnt)
  );

  task automatic clear_inputs();
    MemRead_ex = 0; rdAddr_ex = 0; rs1Addr_id = 0; rs2Addr_id = 0;
    rs1Used_id = 0; rs2Used_id = 0; branch_taken_ex = 0;
    dmem_req_mem = 0; dmem_ready = 0;
  endtask

  // Every task starts and ends 1ns after a rising edge.
  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic apply_reset();
    clear_inputs();
    rst_n = 0;
    tick();
    rst_n = 1;
  endtask

  task automatic test_reset();
    clear_inputs();
    rst_n = 0;
    #2;
    checks++; if (outs !== O_RST) begin failures++; $display("FAIL reset_outs got %b want %b", outs, O_RST); end
    checks++; if (mem_err !== 1'b0) begin failures++; $display("FAIL reset_err got %b want 0", mem_err); end
    checks++; if (stall_cnt !== 3'd0) begin failures++; $display("FAIL reset_cnt got %0d want 0", stall_cnt); end
    tick();
    rst_n = 1;
    #2;
    checks++; if (outs !== O_DEF) begin failures++; $display("FAIL post_reset_outs got %b want %b", outs, O_DEF); end
  endtask

  task automatic test_load_use();
    apply_reset();
    MemRead_ex = 1; rdAddr_ex = 5; rs1Addr_id = 5; rs1Used_id = 1;
    #2;
    checks++; if (outs !== O_LU) begin failures++; $display("FAIL lu_rs1 got %b want %b", outs, O_LU); end
    tick();
    MemRead_ex = 0;  // load has moved to MEM
    #2;
    checks++; if (outs !== O_DEF) begin failures++; $display("FAIL lu_after got %b want %b", outs, O_DEF); end
    checks++; if (stall_cnt !== 3'd1) begin failures++; $display("FAIL lu_cnt got %0d want 1", stall_cnt); end
    MemRead_ex = 1; rdAddr_ex = 0; rs1Addr_id = 0;
    #2;
    checks++; if (outs !== O_DEF) begin failures++; $display("FAIL lu_x0 got %b want %b", outs, O_DEF); end
    rdAddr_ex = 7; rs1Addr_id = 3; rs2Addr_id = 7; rs2Used_id = 1;
    #2;
    checks++; if (outs !== O_LU) begin failures++; $display("FAIL lu_rs2 got %b want %b", outs, O_LU); end
    rs2Used_id = 0;
    #2;
    checks++; if (outs !== O_DEF) begin failures++; $display("FAIL lu_rs2_unused got %b want %b", outs, O_DEF); end
    tick();
    checks++; if (stall_cnt !== 3'd1) begin failures++; $display("FAIL lu_x0_cnt got %0d want 1", stall_cnt); end
  endtask

  task automatic test_branch_priority();
    apply_reset();
    MemRead_ex = 1; rdAddr_ex = 5; rs1Addr_id = 5; rs1Used_id = 1;
    branch_taken_ex = 1;
    #2;
    checks++; if (outs !== O_BR) begin failures++; $display("FAIL br_over_lu got %b want %b", outs, O_BR); end
    tick();
    checks++; if (stall_cnt !== 3'd0) begin failures++; $display("FAIL br_cnt got %0d want 0", stall_cnt); end
  endtask

  task automatic test_mem_wait();
    apply_reset();
    dmem_req_mem = 1; dmem_ready = 0;
    for (int i = 0; i < 3; i++) begin
      #2;
      checks++; if (outs !== O_FRZ) begin failures++; $display("FAIL mw_freeze%0d got %b want %b", i, outs, O_FRZ); end
      tick();
    end
    dmem_ready = 1;
    #2;
    checks++; if (outs !== O_DEF) begin failures++; $display("FAIL mw_release got %b want %b", outs, O_DEF); end
    checks++; if (stall_cnt !== 3'd3) begin failures++; $display("FAIL mw_cnt got %0d want 3", stall_cnt); end
    tick();
    dmem_req_mem = 1; dmem_ready = 1;  // hit in RUN: no stall
    #2;
    checks++; if (outs !== O_DEF) begin failures++; $display("FAIL mw_hit got %b want %b", outs, O_DEF); end
    tick();
    checks++; if (stall_cnt !== 3'd3) begin failures++; $display("FAIL mw_hit_cnt got %0d want 3", stall_cnt); end
  endtask

  task automatic test_back_to_back();
    apply_reset();
    dmem_req_mem = 1; dmem_ready = 0;
    tick();                              // -> MEM_WAIT
    dmem_ready = 1; branch_taken_ex = 1; // release + branch
    #2;
    checks++; if (outs !== O_BR) begin failures++; $display("FAIL b2b_rel_br got %b want %b", outs, O_BR); end
    tick();                              // back in RUN
    branch_taken_ex = 0; dmem_ready = 0;
    #2;
    checks++; if (outs !== O_FRZ) begin failures++; $display("FAIL b2b_reenter got %b want %b", outs, O_FRZ); end
    tick();                              // MEM_WAIT again
    dmem_ready = 1;
    MemRead_ex = 1; rdAddr_ex = 9; rs2Addr_id = 9; rs2Used_id = 1;
    #2;
    checks++; if (outs !== O_LU) begin failures++; $display("FAIL b2b_rel_lu got %b want %b", outs, O_LU); end
    tick();
    clear_inputs();
    #2;
    checks++; if (outs !== O_DEF) begin failures++; $display("FAIL b2b_idle got %b want %b", outs, O_DEF); end
    checks++; if (stall_cnt !== 3'd3) begin failures++; $display("FAIL b2b_cnt got %0d want 3", stall_cnt); end
  endtask

  task automatic test_timeout();
    apply_reset();
    dmem_req_mem = 1; dmem_ready = 0;
    repeat (4) tick();                   // RUN entry + wait_cnt 1..3
    #2;
    checks++; if (outs !== O_FRZ) begin failures++; $display("FAIL to_last_wait got %b want %b", outs, O_FRZ); end
    checks++; if (mem_err !== 1'b0) begin failures++; $display("FAIL to_early_err got %b want 0", mem_err); end
    tick();                              // wait_cnt==4 -> ERR
    #2;
    checks++; if (mem_err !== 1'b1) begin failures++; $display("FAIL to_err got %b want 1", mem_err); end
    checks++; if (outs !== O_ERR) begin failures++; $display("FAIL to_err_outs got %b want %b", outs, O_ERR); end
    checks++; if (stall_cnt !== 3'd5) begin failures++; $display("FAIL to_cnt got %0d want 5", stall_cnt); end
    dmem_ready = 1;                      // ERR ignores ready
    repeat (3) tick();
    #2;
    checks++; if (outs !== O_ERR) begin failures++; $display("FAIL to_sticky got %b want %b", outs, O_ERR); end
    checks++; if (stall_cnt !== 3'd7) begin failures++; $display("FAIL to_cnt_sat got %0d want 7", stall_cnt); end
    rst_n = 0;
    #1;
    checks++; if (mem_err !== 1'b0) begin failures++; $display("FAIL to_rst_err got %b want 0", mem_err); end
    checks++; if (outs !== O_RST) begin failures++; $display("FAIL to_rst_outs got %b want %b", outs, O_RST); end
    clear_inputs();
    tick();
    rst_n = 1;
    #2;
    checks++; if (outs !== O_DEF) begin failures++; $display("FAIL to_after_rst got %b want %b", outs, O_DEF); end
  endtask

  task automatic test_saturate();
    apply_reset();
    MemRead_ex = 1; rdAddr_ex = 12; rs1Addr_id = 12; rs1Used_id = 1;
    repeat (10) tick();
    #2;
    checks++; if (stall_cnt !== 3'd7) begin failures++; $display("FAIL sat_cnt got %0d want 7", stall_cnt); end
    checks++; if (outs !== O_LU) begin failures++; $display("FAIL sat_outs got %b want %b", outs, O_LU); end
  endtask

  task automatic test_async_reset_midwait();
    apply_reset();
    dmem_req_mem = 1; dmem_ready = 0;
    repeat (2) tick();                   // MEM_WAIT, wait_cnt=2
    #3;
    rst_n = 0;                           // between edges
    #1;
    checks++; if (outs !== O_RST) begin failures++; $display("FAIL ar_outs got %b want %b", outs, O_RST); end
    checks++; if (stall_cnt !== 3'd0) begin failures++; $display("FAIL ar_cnt got %0d want 0", stall_cnt); end
    tick();
    rst_n = 1;
    #2;
    // Stays RUN with ready low: freeze again, and a fresh wait must take
    // five edges to time out, proving wait_cnt restarted.
    checks++; if (outs !== O_FRZ) begin failures++; $display("FAIL ar_rerun got %b want %b", outs, O_FRZ); end
    repeat (4) tick();
    checks++; if (mem_err !== 1'b0) begin failures++; $display("FAIL ar_wc_cleared got %b want 0", mem_err); end
    tick();
    checks++; if (mem_err !== 1'b1) begin failures++; $display("FAIL ar_timeout got %b want 1", mem_err); end
    clear_inputs();
    #2;
    dmem_req_mem = 0;
    rst_n = 0;
    #2;
    checks++; if (outs !== O_RST) begin failures++; $display("FAIL ar_err_rst got %b want %b", outs, O_RST); end
    tick();
    rst_n = 1;
    #2;
    checks++; if (outs !== O_DEF) begin failures++; $display("FAIL ar_final got %b want %b", outs, O_DEF); end
  endtask

  initial begin
    rst_n = 0;
    clear_inputs();
    #1;
    test_reset();
    test_load_use();
    test_branch_priority();
    test_mem_wait();
    test_back_to_back();
    test_timeout();
    test_saturate();
    test_async_reset_midwait();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
